// File: rtl/ru_lsu_pkg.sv
// Purpose: shared types, funct3 codes and lane helpers for the load/store unit.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package ru_lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MERGE,
        ST_WACK,
        ST_ERR
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Byte lane of a little-endian word selected by the byte offset.
    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] off);
        return word[{off, 3'b000} +: 8];
    endfunction

    // Half lane selected by offset bit 1 (bit 0 is zero for aligned halves).
    function automatic logic [15:0] half_lane(input logic [31:0] word, input logic off_hi);
        return word[{off_hi, 4'b0000} +: 16];
    endfunction

    // Unsigned variants exist for loads only; 011 and 11x never exist.
    function automatic logic f3_illegal(input logic [2:0] f3, input logic write);
        return !((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (!write && ((f3 == F3_BU) || (f3 == F3_HU))));
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        return (((f3 == F3_H) || (f3 == F3_HU)) && off[0]) ||
               ((f3 == F3_W) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/ru_lsu_if.sv
// Purpose: core-side request/response bundle of the load/store unit.
// Latency: n/a (wires only).
// Backpressure: core holds the request stable while busy is high.
interface ru_lsu_if;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  busy, done, err, rdata
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        output busy, done, err, rdata
    );
endinterface

// File: rtl/ru_lsu_align.sv
// Purpose: combinational load lane extract/extend and sub-word store merge.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; follows its inputs.
module ru_lsu_align
    import ru_lsu_pkg::*;
(
    input  logic [31:0] ram_dout,
    input  logic [15:0] wdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  b;
    logic [15:0] h;

    assign b = byte_lane(ram_dout, offset);
    assign h = half_lane(ram_dout, offset[1]);

    // Load result: pick the addressed lane and sign/zero extend it.
    always_comb begin
        load_data = ram_dout;
        case (funct3)
            F3_B:    load_data = {{24{b[7]}}, b};
            F3_BU:   load_data = {24'h0, b};
            F3_H:    load_data = {{16{h[15]}}, h};
            F3_HU:   load_data = {16'h0, h};
            default: load_data = ram_dout;
        endcase
    end

    // Store merge: old word with only the addressed byte/half replaced.
    always_comb begin
        merge_data = ram_dout;
        if (funct3 == F3_B)
            merge_data[{offset, 3'b000} +: 8] = wdata[7:0];
        else if (funct3 == F3_H)
            merge_data[{offset[1], 4'b0000} +: 16] = wdata;
    end

endmodule

// File: rtl/ru_lsu.sv
// Purpose: MEM-stage load/store unit onto a word RAM; RMW for SB/SH; optional display reg (RU_LSU_DISPLAY_EN).
// Latency: every op completes with done exactly one cycle after acceptance.
// Backpressure: busy = req_valid & ~done stalls the core; no bubble needed between ops.
module ru_lsu
    import ru_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    ru_lsu_if.slave               core,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_write_en,
    input  logic [DATA_WIDTH-1:0] ram_dout
`ifdef RU_LSU_DISPLAY_EN
    ,
    output logic [31:0]           display
`endif
);

    lsu_state_t            state;
    logic                  done_q;
    logic                  err_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [1:0]            off_q;
    logic [2:0]            f3_q;
    logic [15:0]           wdata_q;

    logic                  accept;
    logic                  bad_req;
    logic [31:0]           load_data;
    logic [31:0]           merge_data;
    logic                  unused_addr_hi;

    // Address bits above the RAM range wrap and are deliberately ignored.
    assign unused_addr_hi = ^core.req_addr[31:ADDR_WIDTH+2];

    assign accept  = (state == ST_IDLE) && core.req_valid;
    assign bad_req = f3_illegal(core.req_funct3, core.req_write) ||
                     f3_misaligned(core.req_funct3, core.req_addr[1:0]);

    // Request fields are latched so the op finishes even if the core drops them.
    assign ram_addr = (state == ST_IDLE) ? core.req_addr[ADDR_WIDTH+1:2] : waddr_q;
    assign ram_din  = (state == ST_MERGE) ? merge_data : core.req_wdata;

    // SW writes straight from IDLE; SB/SH write the merged word in MERGE.
    assign ram_write_en = !rst && ((accept && core.req_write && !bad_req &&
                                    (core.req_funct3 == F3_W)) ||
                                   (state == ST_MERGE));

    assign core.done  = done_q && !rst;
    assign core.err   = err_q && !rst;
    assign core.rdata = ((state == ST_LOAD) && !rst) ? load_data : 32'h0;
    assign core.busy  = core.req_valid && !core.done;

    ru_lsu_align u_align (
        .ram_dout   (ram_dout),
        .wdata      (wdata_q),
        .funct3     (f3_q),
        .offset     (off_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    // Control FSM: accept in IDLE, spend exactly one cycle in the op state, return.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            waddr_q <= '0;
            off_q   <= 2'b00;
            f3_q    <= 3'b000;
            wdata_q <= 16'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        waddr_q <= core.req_addr[ADDR_WIDTH+1:2];
                        off_q   <= core.req_addr[1:0];
                        f3_q    <= core.req_funct3;
                        wdata_q <= core.req_wdata[15:0];
                        done_q  <= 1'b1;
                        err_q   <= bad_req;
                        if (bad_req)
                            state <= ST_ERR;
                        else if (!core.req_write)
                            state <= ST_LOAD;
                        else if (core.req_funct3 == F3_W)
                            state <= ST_WACK;
                        else
                            state <= ST_MERGE;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef RU_LSU_DISPLAY_EN
    // Mirror every full word written to word address 0.
    always_ff @(posedge clk) begin
        if (rst)
            display <= 32'h0;
        else if (ram_write_en && (ram_addr == '0))
            display <= ram_din;
    end
`endif

endmodule

// File: tb/tb_ru_lsu.sv
`timescale 1ns/1ps
module tb_ru_lsu;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ru_lsu_if bus ();

    logic [11:0] ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;
    logic        ram_write_en;
`ifdef RU_LSU_DISPLAY_EN
    logic [31:0] display;
`endif

    ru_lsu #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .core         (bus),
        .ram_addr     (ram_addr),
        .ram_din      (ram_din),
        .ram_write_en (ram_write_en),
        .ram_dout     (ram_dout)
`ifdef RU_LSU_DISPLAY_EN
        ,
        .display      (display)
`endif
    );

    // Word RAM: registered read, old data on read-during-write, backdoor preload port.
    logic [31:0] mem [0:4095] = '{default: 32'h0};
    logic        bd_we = 1'b0;
    logic [11:0] bd_addr = 12'h0;
    logic [31:0] bd_dat = 32'h0;
    always @(posedge clk) begin
        if (ram_write_en === 1'b1)
            mem[ram_addr] <= ram_din;
        else if (bd_we)
            mem[bd_addr] <= bd_dat;
        ram_dout <= mem[ram_addr];
    end

    int wr_cnt = 0;
    always @(negedge clk) if (ram_write_en === 1'b1) wr_cnt++;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] gold [0:15];
    logic [31:0] exp_disp = 32'h0;

    function automatic int nbytes(input logic [2:0] f3);
        return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] lane_mask(input int nb);
        return (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [2:0] f3,
                                             input logic [1:0] off);
        logic [31:0] v;
        int nb;
        nb = nbytes(f3);
        v  = (word >> (8 * off)) & lane_mask(nb);
        if (!f3[2] && nb < 4 && v[8 * nb - 1]) v = v | ~lane_mask(nb);
        return v;
    endfunction

    function automatic logic ref_err(input logic w, input logic [2:0] f3, input logic [1:0] off);
        logic legal, mis;
        legal = (f3 <= 3'd2) || (!w && (f3 == 3'd4 || f3 == 3'd5));
        mis   = ((f3 == 3'd1 || f3 == 3'd5) && off[0]) || (f3 == 3'd2 && off != 2'b00);
        return !legal || mis;
    endfunction

    task automatic poke(input logic [11:0] a, input logic [31:0] d);
        bd_addr = a; bd_dat = d; bd_we = 1'b1;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    // Present one request (starting 1ns after a posedge) and wait boundedly for done.
    task automatic run_op(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er,
                          output int lat, output int wr, output logic busy0);
        int w0;
        w0 = wr_cnt;
        bus.req_valid = 1'b1; bus.req_write = w; bus.req_funct3 = f3;
        bus.req_addr = a; bus.req_wdata = wd;
        @(negedge clk);
        busy0 = bus.busy;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 8) begin
            lat++;
            @(negedge clk);
        end
        rd = bus.rdata; er = bus.err;
        @(posedge clk); #1;
        wr = wr_cnt - w0;
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.req_valid = 1'b0; bus.req_write = 1'b0;
        bus.req_funct3 = 3'b010; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        n_cmp++; if ({bus.done, bus.err, ram_write_en} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got=%b want=000", {bus.done, bus.err, ram_write_en}); end
        n_cmp++; if (bus.rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got=%h want=0", bus.rdata); end
        @(posedge clk); #1 rst = 1'b0;
        exp_disp = 32'h0;
        @(negedge clk);
        n_cmp++; if ({bus.busy, bus.done} !== 2'b00) begin n_bad++; $display("FAIL idle_after_reset got=%b want=00", {bus.busy, bus.done}); end
`ifdef RU_LSU_DISPLAY_EN
        n_cmp++; if (display !== 32'h0) begin n_bad++; $display("FAIL reset_display got=%h want=0", display); end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_loads();
        logic [31:0] rd; logic er, b0; int lat, wr;
        poke(12'd4, 32'hDEADBEEF);
        run_op(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, wr, b0);
        n_cmp++; if (b0 !== 1'b1 || lat != 1) begin n_bad++; $display("FAIL lw_timing busy=%b lat=%0d want busy=1 lat=1", b0, lat); end
        n_cmp++; if (rd !== 32'hDEADBEEF || er !== 1'b0 || wr != 0) begin n_bad++; $display("FAIL lw_result rd=%h err=%b wr=%0d want DEADBEEF/0/0", rd, er, wr); end
        poke(12'd4, 32'h11223380);
        run_op(1'b0, 3'b000, 32'h10, 32'h0, rd, er, lat, wr, b0);
        n_cmp++; if (rd !== 32'hFFFFFF80) begin n_bad++; $display("FAIL lb_sext got=%h want=FFFFFF80", rd); end
        run_op(1'b0, 3'b100, 32'h10, 32'h0, rd, er, lat, wr, b0);
        n_cmp++; if (rd !== 32'h00000080) begin n_bad++; $display("FAIL lbu_zext got=%h want=00000080", rd); end
        run_op(1'b0, 3'b001, 32'h12, 32'h0, rd, er, lat, wr, b0);
        n_cmp++; if (rd !== 32'h00001122) begin n_bad++; $display("FAIL lh_upper got=%h want=00001122", rd); end
    endtask

    task automatic test_stores();
        logic [31:0] rd; logic er, b0; int lat, wr;
        poke(12'd4, 32'h11223344);
        run_op(1'b1, 3'b000, 32'h11, 32'h000000AA, rd, er, lat, wr, b0);
        n_cmp++; if (wr != 1 || lat != 1 || er !== 1'b0) begin n_bad++; $display("FAIL sb_write wr=%0d lat=%0d err=%b want 1/1/0", wr, lat, er); end
        n_cmp++; if (mem[4] !== 32'h1122AA44) begin n_bad++; $display("FAIL sb_merge got=%h want=1122AA44", mem[4]); end
        // Back-to-back: the load follows the store with no idle cycle.
        run_op(1'b1, 3'b001, 32'h12, 32'h0000BEEF, rd, er, lat, wr, b0);
        run_op(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, wr, b0);
        n_cmp++; if (rd !== 32'hBEEFAA44 || lat != 1) begin n_bad++; $display("FAIL sh_then_lw got=%h lat=%0d want=BEEFAA44 lat=1", rd, lat); end
        run_op(1'b1, 3'b010, 32'h0, 32'h00000055, rd, er, lat, wr, b0);
        exp_disp = 32'h55;
        n_cmp++; if (mem[0] !== 32'h55 || wr != 1) begin n_bad++; $display("FAIL sw_word0 got=%h wr=%0d want=00000055 wr=1", mem[0], wr); end
`ifdef RU_LSU_DISPLAY_EN
        n_cmp++; if (display !== exp_disp) begin n_bad++; $display("FAIL display got=%h want=%h", display, exp_disp); end
`endif
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er, b0; int lat, wr;
        logic        ew [0:3];
        logic [2:0]  ef [0:3];
        logic [31:0] ea [0:3];
        ew = '{1'b0, 1'b1, 1'b0, 1'b1};
        ef = '{3'b010, 3'b001, 3'b011, 3'b100};
        ea = '{32'h02, 32'h13, 32'h10, 32'h10};
        for (int i = 0; i < 4; i++) begin
            run_op(ew[i], ef[i], ea[i], 32'hFFFF_FFFF, rd, er, lat, wr, b0);
            n_cmp++; if (er !== 1'b1 || rd !== 32'h0 || wr != 0 || lat != 1) begin n_bad++; $display("FAIL err_case%0d err=%b rd=%h wr=%0d lat=%0d want 1/0/0/1", i, er, rd, wr, lat); end
        end
    endtask

    task automatic test_rst_merge();
        logic [31:0] rd; logic er, b0; int lat, wr, w0;
        poke(12'd4, 32'h11223344);
        w0 = wr_cnt;
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h10; bus.req_wdata = 32'h77;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (ram_write_en !== 1'b0 || bus.done !== 1'b0) begin n_bad++; $display("FAIL rst_in_merge we=%b done=%b want 0/0", ram_write_en, bus.done); end
        @(posedge clk); #1 rst = 1'b0; bus.req_valid = 1'b0;
        exp_disp = 32'h0;
        @(negedge clk);
        n_cmp++; if (mem[4] !== 32'h11223344 || wr_cnt != w0 || bus.done !== 1'b0) begin n_bad++; $display("FAIL rst_mem got=%h writes=%0d done=%b want=11223344/0/0", mem[4], wr_cnt - w0, bus.done); end
        @(posedge clk); #1;
        run_op(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, wr, b0);
        n_cmp++; if (rd !== 32'h11223344 || lat != 1) begin n_bad++; $display("FAIL idle_after_rst rd=%h lat=%0d want=11223344 lat=1", rd, lat); end
    endtask

    task automatic test_valid_drop();
        int pulses;
        poke(12'd7, 32'hCAFE1234);
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_funct3 = 3'b101; bus.req_addr = 32'h1E;
        @(posedge clk); #1 bus.req_valid = 1'b0; bus.req_addr = 32'h0; bus.req_funct3 = 3'b010;
        @(negedge clk);
        n_cmp++; if (bus.done !== 1'b1 || bus.rdata !== 32'h0000CAFE) begin n_bad++; $display("FAIL valid_drop done=%b rd=%h want 1/0000CAFE", bus.done, bus.rdata); end
        pulses = 0;
        repeat (3) begin @(negedge clk); if (bus.done === 1'b1) pulses++; end
        n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL done_once extra=%0d want=0", pulses); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [31:0] rd, a, wd, exp_rd; logic er, b0, w, exp_er; logic [2:0] f3;
        int lat, wr, widx, nb, sh;
        for (int i = 0; i < 16; i++) begin
            gold[i] = $urandom;
            poke(12'(i), gold[i]);
        end
        for (int n = 0; n < 300; n++) begin
            w    = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            widx = $urandom_range(0, 15);
            a    = ($urandom & 32'hFFFF_C000) | (32'(widx) << 2) | 32'($urandom_range(0, 3));
            wd   = $urandom;
            exp_er = ref_err(w, f3, a[1:0]);
            exp_rd = (!exp_er && !w) ? ref_load(gold[widx], f3, a[1:0]) : 32'h0;
            run_op(w, f3, a, wd, rd, er, lat, wr, b0);
            if (!exp_er && w) begin
                nb = nbytes(f3);
                sh = 8 * a[1:0];
                gold[widx] = (gold[widx] & ~(lane_mask(nb) << sh)) | ((wd & lane_mask(nb)) << sh);
                if (widx == 0) exp_disp = gold[0];
            end
            n_cmp++; if (rd !== exp_rd || er !== exp_er) begin n_bad++; $display("FAIL rand%0d w=%b f3=%b a=%h rd=%h err=%b want %h/%b", n, w, f3, a, rd, er, exp_rd, exp_er); end
            n_cmp++; if (lat != 1 || wr != ((!exp_er && w) ? 1 : 0)) begin n_bad++; $display("FAIL rand%0d_timing lat=%0d wr=%0d want lat=1 wr=%0d", n, lat, wr, (!exp_er && w) ? 1 : 0); end
`ifdef RU_LSU_DISPLAY_EN
            n_cmp++; if (display !== exp_disp) begin n_bad++; $display("FAIL rand%0d_display got=%h want=%h", n, display, exp_disp); end
`endif
        end
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (mem[i] !== gold[i]) begin n_bad++; $display("FAIL rand_mem[%0d] got=%h want=%h", i, mem[i], gold[i]); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_errors();
        test_rst_merge();
        test_valid_drop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
